// File: rtl/fb_scanout_pkg.sv
// Shared definitions for the framebuffer scanout block: screen geometry,
// framebuffer placement, FSM state encoding and the byte-index helper.
package fb_scanout_pkg;

    localparam int          SCREEN_W        = 64;
    localparam int          SCREEN_H        = 32;
    localparam int          FB_BYTES        = 256;
    localparam logic [11:0] FB_BASE_DEFAULT = 12'h100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    // Byte offset inside the framebuffer: 8 bytes per row, column byte = x[5:3]
    function automatic logic [7:0] byte_index(input logic [2:0] col_byte, input logic [4:0] row);
        return {row, col_byte};
    endfunction

endpackage

// File: rtl/fb_scanout_shifter.sv
// Pixel shifter for fb_scanout: holds the current framebuffer byte, presents
// bit 7 as the pixel and shifts left on every accepted beat. A load always
// wins over a shift so the next byte can replace the last bit seamlessly.
module fb_scanout_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       active,
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic       pix_data,
    output logic       fire,
    output logic       last_beat
);

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;

    assign pix_valid = active;
    assign pix_data  = active & shift_reg[7];
    assign fire      = active & pix_ready;
    assign last_beat = fire && (bit_cnt == 3'd7);

    // Load a fresh byte or advance one pixel per accepted beat; otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 8'd0;
            bit_cnt   <= 3'd0;
        end else if (load) begin
            shift_reg <= load_data;
            bit_cnt   <= 3'd0;
        end else if (fire) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            bit_cnt   <= bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: reads the 64x32 monochrome framebuffer over the shared memory
// read port and streams pixels in raster order on a valid/ready port.
// Optional build macro FB_SCANOUT_PREFETCH_EN adds a one-byte prefetch buffer
// so the next byte is fetched while the current one is being shifted out.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter logic [11:0] FB_BASE = FB_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        frame_done,
    output logic        mem_read,
    output logic [11:0] mem_read_idx,
    input  logic [7:0]  mem_read_byte,
    input  logic        mem_read_ack,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic [5:0]  pix_x,
    output logic [4:0]  pix_y
);

    scan_state_t state;
    scan_state_t state_next;

    logic [5:0]  x;
    logic [4:0]  y;
    logic [7:0]  byte_idx;
    logic [11:0] fetch_addr;
    logic        frame_last;
    logic        shift_active;
    logic        fire;
    logic        last_beat;
    logic        load;
    logic [7:0]  load_data;

    assign byte_idx     = byte_index(x[5:3], y);
    assign fetch_addr   = FB_BASE + {4'd0, byte_idx};
    assign frame_last   = (x == 6'(SCREEN_W - 1)) && (y == 5'(SCREEN_H - 1));
    assign shift_active = (state == ST_SHIFT);
    assign pix_x        = x;
    assign pix_y        = y;

`ifdef FB_SCANOUT_PREFETCH_EN
    logic       pf_valid;
    logic [7:0] pf_byte;
    logic       pf_req;
    logic       pf_hit;

    // The next byte is requested as soon as shifting of the current one begins,
    // except for the final byte of the frame
    assign pf_req    = shift_active && !pf_valid && (byte_idx != 8'(FB_BYTES - 1));
    assign pf_hit    = pf_valid || (pf_req && mem_read_ack);
    assign load      = (state == ST_FETCH && mem_read_ack) ||
                       (last_beat && !frame_last && pf_hit);
    assign load_data = (shift_active && pf_valid) ? pf_byte : mem_read_byte;

    // Capture a prefetched byte; it is consumed (or dropped) at the byte boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_valid <= 1'b0;
            pf_byte  <= 8'd0;
        end else if (!shift_active || last_beat) begin
            pf_valid <= 1'b0;
        end else if (pf_req && mem_read_ack) begin
            pf_valid <= 1'b1;
            pf_byte  <= mem_read_byte;
        end
    end
`else
    assign load      = (state == ST_FETCH) && mem_read_ack;
    assign load_data = mem_read_byte;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fetch a byte, shift it out, repeat until the last pixel
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_FETCH;
            ST_FETCH: if (mem_read_ack) state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (last_beat) begin
                    if (frame_last) begin
                        state_next = ST_DONE;
`ifdef FB_SCANOUT_PREFETCH_EN
                    end else if (!pf_hit) begin
                        state_next = ST_FETCH;
`else
                    end else begin
                        state_next = ST_FETCH;
`endif
                    end
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode: status flags and the memory read request
    always_comb begin
        busy         = (state != ST_IDLE);
        frame_done   = (state == ST_DONE);
        mem_read     = 1'b0;
        mem_read_idx = 12'd0;
        if (state == ST_FETCH) begin
            mem_read     = 1'b1;
            mem_read_idx = fetch_addr;
        end
`ifdef FB_SCANOUT_PREFETCH_EN
        if (pf_req) begin
            mem_read     = 1'b1;
            mem_read_idx = fetch_addr + 12'd1;
        end
`endif
    end

    // Raster position: advances on each accepted beat, row steps on x wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= 6'd0;
            y <= 5'd0;
        end else if (state == ST_IDLE && start) begin
            x <= 6'd0;
            y <= 5'd0;
        end else if (fire) begin
            x <= x + 6'd1;
            if (x == 6'(SCREEN_W - 1)) begin
                y <= y + 5'd1;
            end
        end
    end

    fb_scanout_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .active    (shift_active),
        .pix_ready (pix_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .fire      (fire),
        .last_beat (last_beat)
    );

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout: a memory responder with random or fixed ack
// latency, a pixel sink with optional random backpressure, and a frame model
// that predicts every beat directly from the framebuffer contents.
module tb_fb_scanout;

    localparam logic [11:0] FB_BASE = 12'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte = 8'd0;
    logic        mem_read_ack = 1'b0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_data;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;

    logic [7:0]  mem [0:255];

    int checks = 0;
    int failures = 0;
    int beat_cnt = 0;
    int read_cnt = 0;
    int done_cnt = 0;
    int gap_cnt = 0;
    int fixed_lat = -1;
    bit rand_ready = 1'b0;
    bit stall_en = 1'b0;
    bit late_ack_req = 1'b0;
    int stall_left = 0;
    bit pend = 1'b0;
    int wait_cnt = 0;
    int cur_lat = 0;
    logic [11:0] pend_idx = 12'd0;
    bit prev_stalled = 1'b0;
    logic [12:0] prev_snap = 13'd0;
    bit last_final = 1'b0;
    bit done_prev = 1'b0;
    bit accepted;
    logic [7:0] exp_byte;
    logic [5:0] exp_x;
    logic [4:0] exp_y;
    logic       exp_d;

    fb_scanout dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .frame_done    (frame_done),
        .mem_read      (mem_read),
        .mem_read_idx  (mem_read_idx),
        .mem_read_byte (mem_read_byte),
        .mem_read_ack  (mem_read_ack),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_data      (pix_data),
        .pix_x         (pix_x),
        .pix_y         (pix_y)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic fillMem(input bit random_fill);
        for (int i = 0; i < 256; i++) begin
            mem[i] = random_fill ? 8'($urandom) : 8'd0;
        end
    endtask

    // Run one frame from start to frame_done; optionally poke start mid-frame
    // and on the frame_done cycle, both of which must be ignored
    task automatic applyStimulus(input bit mid_start, input bit done_start);
        int  cyc;
        bit  pulsed;
        beat_cnt = 0;
        read_cnt = 0;
        done_cnt = 0;
        gap_cnt  = 0;
        pulsed   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_start", 32'(busy), 32'd1);
        cyc = 0;
        while (!frame_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (start) begin
                start = 1'b0;
            end else if (mid_start && !pulsed && beat_cnt >= 500 && !frame_done) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        checkOutput("frame_timeout", 32'(frame_done), 32'd1);
        start = done_start;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("busy_idle", 32'(busy), 32'd0);
        checkOutput("one_frame", 32'(done_cnt), 32'd1);
        checkOutput("frame_beats", 32'(beat_cnt), 32'd2048);
        checkOutput("frame_reads", 32'(read_cnt), 32'd256);
    endtask

    // Memory responder, pixel sink and frame model, all sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_read_ack = 1'b0;
                pend         = 1'b0;
                prev_stalled = 1'b0;
                last_final   = 1'b0;
                done_prev    = 1'b0;
                stall_left   = 0;
            end else begin
                mem_read_ack = 1'b0;
                if (late_ack_req) begin
                    late_ack_req  = 1'b0;
                    mem_read_ack  = 1'b1;
                    mem_read_byte = 8'hA5;
                end else if (mem_read) begin
                    if (!pend) begin
                        pend     = 1'b1;
                        pend_idx = mem_read_idx;
                        wait_cnt = 0;
                        cur_lat  = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
                        checkOutput("rd_addr", 32'(mem_read_idx), 32'(FB_BASE + 12'(read_cnt)));
                        checkOutput("rd_range", 32'(mem_read_idx >= 12'h100 && mem_read_idx <= 12'h1FF), 32'd1);
                    end else begin
                        checkOutput("rd_stable", 32'(mem_read_idx), 32'(pend_idx));
                    end
                    if (wait_cnt >= cur_lat) begin
                        mem_read_byte = mem[mem_read_idx[7:0]];
                        mem_read_ack  = 1'b1;
                        read_cnt++;
                        pend = 1'b0;
                    end else begin
                        wait_cnt++;
                    end
                end
                checkOutput("idle_read", 32'(mem_read & ~busy), 32'd0);

                if (stall_left > 0) begin
                    pix_ready = 1'b0;
                    stall_left--;
                end else if (stall_en && pix_valid && beat_cnt == 3) begin
                    pix_ready  = 1'b0;
                    stall_left = 4;
                    stall_en   = 1'b0;
                end else begin
                    pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                end

                if (prev_stalled) begin
                    checkOutput("hold", 32'({pix_valid, pix_data, pix_x, pix_y}), 32'(prev_snap));
                end

                if (frame_done) begin
                    done_cnt++;
                    checkOutput("done_beats", 32'(beat_cnt), 32'd2048);
                    checkOutput("done_reads", 32'(read_cnt), 32'd256);
                    checkOutput("done_after_last", 32'(last_final), 32'd1);
                end
                if (done_prev) begin
                    checkOutput("busy_after_done", 32'(busy), 32'd0);
                end

                if (busy && beat_cnt > 0 && beat_cnt < 2048 && !pix_valid) begin
                    gap_cnt++;
                end

                accepted = pix_valid && pix_ready;
                if (accepted) begin
                    if (beat_cnt >= 2048) begin
                        checkOutput("extra_beat", 32'(beat_cnt), 32'd2047);
                    end else begin
                        exp_byte = mem[beat_cnt / 8];
                        exp_x    = 6'(beat_cnt % 64);
                        exp_y    = 5'(beat_cnt / 64);
                        exp_d    = exp_byte[7 - (beat_cnt % 8)];
                        checkOutput("beat", 32'({pix_x, pix_y, pix_data}), 32'({exp_x, exp_y, exp_d}));
                    end
                    beat_cnt++;
                end
                last_final   = accepted && (beat_cnt == 2048);
                done_prev    = frame_done;
                prev_stalled = pix_valid && !pix_ready;
                prev_snap    = {pix_valid, pix_data, pix_x, pix_y};
            end
        end
    end

    initial begin
        int cyc;
        fillMem(1'b0);
        #1 rst_n = 1'b0;
        #20;
        checkOutput("reset_outputs",
                    32'({busy, frame_done, mem_read, pix_valid, pix_data, mem_read_idx, pix_x, pix_y}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_no_read", 32'({busy, mem_read}), 32'd0);

        $display("[TB] frame with two patterned rows");
        mem[0] = 8'hFF;
        mem[8] = 8'hC3;
        applyStimulus(1'b0, 1'b0);

        $display("[TB] backpressure at beat (3,0)");
        stall_en = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("stall_seen", 32'(stall_en), 32'd0);

        $display("[TB] last pixel only");
        fillMem(1'b0);
        mem[255] = 8'h01;
        applyStimulus(1'b0, 1'b0);

        $display("[TB] start pulses during frame and on frame_done");
        fillMem(1'b1);
        applyStimulus(1'b1, 1'b1);

        $display("[TB] reset mid-frame with a read outstanding");
        fillMem(1'b1);
        beat_cnt = 0;
        read_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(beat_cnt >= 340 && mem_read) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reset_point_reached", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset",
                    32'({busy, frame_done, mem_read, pix_valid, pix_data, mem_read_idx, pix_x, pix_y}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late_ack_req = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("late_ack_ignored", 32'({busy, mem_read, pix_valid}), 32'd0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] ack latency 1 with sink always ready");
        fillMem(1'b1);
        fixed_lat = 1;
        applyStimulus(1'b0, 1'b0);
`ifdef FB_SCANOUT_PREFETCH_EN
        checkOutput("gapless", 32'(gap_cnt), 32'd0);
`else
        checkOutput("gaps_present", 32'(gap_cnt > 0), 32'd1);
`endif

        $display("[TB] random memory, random latency, random backpressure");
        fillMem(1'b1);
        fixed_lat  = -1;
        rand_ready = 1'b1;
        applyStimulus(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
